// File: rtl/vga_rx_timing_pkg.sv
// Shared types and mode arithmetic for the VGA sink-side timing receiver.
package vga_rx_timing_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    // Default mode: 1280x1024 timing.
    localparam int DEF_HD      = 1280;
    localparam int DEF_HF      = 48;
    localparam int DEF_HR      = 112;
    localparam int DEF_HB      = 248;
    localparam int DEF_VD      = 1024;
    localparam int DEF_VF      = 1;
    localparam int DEF_VR      = 3;
    localparam int DEF_VB      = 38;
    localparam int DEF_PIX_DLY = 1;

    // Total period of one axis: display + front porch + sync + back porch.
    function automatic int mode_total(input int d, input int f, input int r, input int b);
        return d + f + r + b;
    endfunction

    // First active position of one axis, counted from the sync rise.
    function automatic int act_start(input int r, input int b, input int dly);
        return r + b + dly;
    endfunction

    localparam int H_TOTAL     = mode_total(DEF_HD, DEF_HF, DEF_HR, DEF_HB);
    localparam int V_TOTAL     = mode_total(DEF_VD, DEF_VF, DEF_VR, DEF_VB);
    localparam int H_ACT_START = act_start(DEF_HR, DEF_HB, DEF_PIX_DLY);
    localparam int V_ACT_START = act_start(DEF_VR, DEF_VB, 0);

endpackage

// File: rtl/vga_sync_meas.sv
// Period and high-width counter for one sync signal. The event input restarts the
// period; the count-enable advances it. Both counters saturate instead of wrapping.
module vga_sync_meas #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         level_i,   // sync level, sampled on counting steps
    input  logic         event_i,   // sync rise: period ends, new one starts
    input  logic         en_i,      // count step
    output logic [W-1:0] cnt_o,     // running position within the period
    output logic [W-1:0] wid_o,     // running high-time of the period
    output logic         sat_o,     // running position stuck at all-ones
    output logic [W-1:0] period_o   // last completed period length
);

    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] wid_q, wid_d;
    logic [W-1:0] period_q, period_d;
    logic         cnt_sat_s;
    logic         wid_sat_s;

    assign cnt_sat_s = (cnt_q == CNT_MAX);
    assign wid_sat_s = (wid_q == CNT_MAX);

    // Next-state of the counters; the event cycle itself is high, so width restarts at 1.
    always_comb begin
        cnt_d    = cnt_q;
        wid_d    = wid_q;
        period_d = period_q;
        if (event_i) begin
            cnt_d    = {W{1'b0}};
            wid_d    = ONE;
            period_d = cnt_sat_s ? CNT_MAX : (cnt_q + ONE);
        end else if (en_i) begin
            if (!cnt_sat_s) begin
                cnt_d = cnt_q + ONE;
            end else begin
                cnt_d = cnt_q;
            end
            if (level_i && !wid_sat_s) begin
                wid_d = wid_q + ONE;
            end else begin
                wid_d = wid_q;
            end
        end else begin
            cnt_d = cnt_q;
            wid_d = wid_q;
        end
    end

    // Counter and measurement registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= {W{1'b0}};
            wid_q    <= {W{1'b0}};
            period_q <= {W{1'b0}};
        end else begin
            cnt_q    <= cnt_d;
            wid_q    <= wid_d;
            period_q <= period_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign wid_o    = wid_q;
    assign sat_o    = cnt_sat_s;
    assign period_o = period_q;

endmodule

// File: rtl/vga_rx_timing.sv
// VGA sink-side timing receiver: measures HS/VS timing against the expected mode,
// locks after a run of clean frames and recovers active-area pixel coordinates.
module vga_rx_timing
    import vga_rx_timing_pkg::*;
#(
    parameter int HSYNC_BITS  = 11,
    parameter int VSYNC_BITS  = 11,
    parameter int HD          = DEF_HD,
    parameter int HF          = DEF_HF,
    parameter int HR          = DEF_HR,
    parameter int HB          = DEF_HB,
    parameter int VD          = DEF_VD,
    parameter int VF          = DEF_VF,
    parameter int VR          = DEF_VR,
    parameter int VB          = DEF_VB,
    parameter int PIX_DLY     = DEF_PIX_DLY,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  VGA_HS,
    input  logic                  VGA_VS,
    input  logic [11:0]           RGB,
    output logic [HSYNC_BITS-1:0] pix_x,
    output logic [VSYNC_BITS-1:0] pix_y,
    output logic                  pix_valid,
    output logic [11:0]           pix_rgb,
    output logic                  frame_start,
    output logic                  locked,
    output logic [HSYNC_BITS-1:0] line_len,
    output logic [VSYNC_BITS-1:0] frame_lines,
    output logic [7:0]            err_cnt
);

    localparam int H_TOT = mode_total(HD, HF, HR, HB);
    localparam int V_TOT = mode_total(VD, VF, VR, VB);
    localparam int H_ACT = act_start(HR, HB, PIX_DLY);
    localparam int V_ACT = act_start(VR, VB, 0);

    localparam logic [HSYNC_BITS-1:0] H_ONE       = {{(HSYNC_BITS-1){1'b0}}, 1'b1};
    localparam logic [VSYNC_BITS-1:0] V_ONE       = {{(VSYNC_BITS-1){1'b0}}, 1'b1};
    localparam logic [HSYNC_BITS-1:0] H_TOT_W     = HSYNC_BITS'(H_TOT);
    localparam logic [VSYNC_BITS-1:0] V_TOT_W     = VSYNC_BITS'(V_TOT);
    localparam logic [HSYNC_BITS-1:0] HR_W        = HSYNC_BITS'(HR);
    localparam logic [VSYNC_BITS-1:0] VR_W        = VSYNC_BITS'(VR);
    localparam logic [HSYNC_BITS-1:0] H_ACT_W     = HSYNC_BITS'(H_ACT);
    localparam logic [HSYNC_BITS-1:0] H_ACT_END_W = HSYNC_BITS'(H_ACT + HD - 1);
    localparam logic [VSYNC_BITS-1:0] V_ACT_W     = VSYNC_BITS'(V_ACT);
    localparam logic [VSYNC_BITS-1:0] V_ACT_END_W = VSYNC_BITS'(V_ACT + VD - 1);
    localparam logic [7:0]            LOCK_W      = 8'(LOCK_FRAMES);

    // Input synchronizer stages.
    logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
    logic [11:0] rgb_s1_q, rgb_s2_q;
    logic        hs_rise_s, vs_rise_s;

    // Measurement results.
    logic [HSYNC_BITS-1:0] h_cnt_s, h_wid_s, line_len_s;
    logic [VSYNC_BITS-1:0] v_cnt_s, v_wid_s, frame_lines_s;
    logic                  h_sat_s, v_sat_s;

    // Frame qualification and FSM.
    logic      line_bad_s, frame_ok_s, any_sat_s;
    logic      frame_bad_q, frame_bad_d;
    rx_state_e state_q, state_d;
    logic [7:0] good_cnt_q, good_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Output path.
    logic                  h_act_s, v_act_s, pix_ok_s;
    logic                  pix_valid_q, pix_valid_d;
    logic [HSYNC_BITS-1:0] pix_x_q, pix_x_d;
    logic [VSYNC_BITS-1:0] pix_y_q, pix_y_d;
    logic [11:0]           pix_rgb_q, pix_rgb_d;
    logic                  frame_start_q, locked_q;

    // Two-stage input registers; edges come from comparing the stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s1_q  <= 1'b0;
            hs_s2_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
            rgb_s1_q <= 12'd0;
            rgb_s2_q <= 12'd0;
        end else begin
            hs_s1_q  <= VGA_HS;
            hs_s2_q  <= hs_s1_q;
            vs_s1_q  <= VGA_VS;
            vs_s2_q  <= vs_s1_q;
            rgb_s1_q <= RGB;
            rgb_s2_q <= rgb_s1_q;
        end
    end

    assign hs_rise_s = hs_s1_q & ~hs_s2_q;
    assign vs_rise_s = vs_s1_q & ~vs_s2_q;

    // Horizontal: clocks within the line and HS high-time.
    vga_sync_meas #(.W(HSYNC_BITS)) u_h_meas (
        .clk      (clk),
        .rst      (rst),
        .level_i  (hs_s1_q),
        .event_i  (hs_rise_s),
        .en_i     (1'b1),
        .cnt_o    (h_cnt_s),
        .wid_o    (h_wid_s),
        .sat_o    (h_sat_s),
        .period_o (line_len_s)
    );

    // Vertical: lines within the frame (steps on HS rises) and VS high-time in lines.
    vga_sync_meas #(.W(VSYNC_BITS)) u_v_meas (
        .clk      (clk),
        .rst      (rst),
        .level_i  (vs_s1_q),
        .event_i  (vs_rise_s),
        .en_i     (hs_rise_s),
        .cnt_o    (v_cnt_s),
        .wid_o    (v_wid_s),
        .sat_o    (v_sat_s),
        .period_o (frame_lines_s)
    );

    // The line ending on an HS rise is judged with the counts as they stand in that cycle.
    assign any_sat_s  = h_sat_s | v_sat_s;
    assign line_bad_s = hs_rise_s & (h_sat_s | ((h_cnt_s + H_ONE) != H_TOT_W) | (h_wid_s != HR_W));
    assign frame_ok_s = ~frame_bad_q & ~line_bad_s & ~any_sat_s &
                        ((v_cnt_s + V_ONE) == V_TOT_W) & (v_wid_s == VR_W);

    // Accumulate bad lines over a frame; the line ending on the VS rise still belongs to the old frame.
    always_comb begin
        frame_bad_d = frame_bad_q;
        if (vs_rise_s) begin
            frame_bad_d = 1'b0;
        end else begin
            frame_bad_d = frame_bad_q | line_bad_s | any_sat_s;
        end
    end

    // Lock FSM next-state, good-frame run counter and lock-loss counter.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            SEARCH: begin
                if (vs_rise_s) begin
                    state_d    = TRACK;
                    good_cnt_d = 8'd0;
                end else begin
                    state_d = SEARCH;
                end
            end
            TRACK: begin
                if (vs_rise_s) begin
                    if (frame_ok_s) begin
                        if ((good_cnt_q + 8'd1) >= LOCK_W) begin
                            state_d    = LOCKED;
                            good_cnt_d = 8'd0;
                        end else begin
                            good_cnt_d = good_cnt_q + 8'd1;
                        end
                    end else begin
                        good_cnt_d = 8'd0;
                    end
                end else begin
                    state_d = TRACK;
                end
            end
            LOCKED: begin
                if (line_bad_s || any_sat_s || (vs_rise_s && !frame_ok_s)) begin
                    state_d    = SEARCH;
                    good_cnt_d = 8'd0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d    = SEARCH;
                good_cnt_d = 8'd0;
            end
        endcase
    end

    // FSM and qualification state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            good_cnt_q  <= 8'd0;
            err_cnt_q   <= 8'd0;
            frame_bad_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            err_cnt_q   <= err_cnt_d;
            frame_bad_q <= frame_bad_d;
        end
    end

    // h_cnt/v_cnt line up with rgb_s2; a pixel is dropped if lock is lost in the same cycle.
    assign h_act_s  = (h_cnt_s >= H_ACT_W) && (h_cnt_s <= H_ACT_END_W);
    assign v_act_s  = (v_cnt_s >= V_ACT_W) && (v_cnt_s <= V_ACT_END_W);
    assign pix_ok_s = (state_q == LOCKED) && (state_d == LOCKED) && h_act_s && v_act_s;

    // Pixel output next-state; everything reads zero outside valid pixels.
    always_comb begin
        pix_valid_d = 1'b0;
        pix_x_d     = {HSYNC_BITS{1'b0}};
        pix_y_d     = {VSYNC_BITS{1'b0}};
        pix_rgb_d   = 12'd0;
        if (pix_ok_s) begin
            pix_valid_d = 1'b1;
            pix_x_d     = h_cnt_s - H_ACT_W;
            pix_y_d     = v_cnt_s - V_ACT_W;
            pix_rgb_d   = rgb_s2_q;
        end else begin
            pix_valid_d = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid_q   <= 1'b0;
            pix_x_q       <= {HSYNC_BITS{1'b0}};
            pix_y_q       <= {VSYNC_BITS{1'b0}};
            pix_rgb_q     <= 12'd0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= vs_rise_s;
            locked_q      <= (state_d == LOCKED);
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign line_len    = line_len_s;
    assign frame_lines = frame_lines_s;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_rx_timing.sv
// Bench for vga_rx_timing in a small mode (16-clock lines, 8-line frames).
// A directed VGA source pushes expected pixels into a queue; a monitor pops and compares.
module tb_vga_rx_timing;

    logic        clk = 1'b0;
    logic        rst;
    logic        VGA_HS, VGA_VS;
    logic [11:0] RGB;
    logic [10:0] pix_x, pix_y;
    logic        pix_valid;
    logic [11:0] pix_rgb;
    logic        frame_start, locked;
    logic [10:0] line_len, frame_lines;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int pix_seen = 0;
    int fs_cnt   = 0;
    bit mon_en   = 1'b0;
    logic [33:0] exp_q[$];

    vga_rx_timing #(
        .HSYNC_BITS(11), .VSYNC_BITS(11),
        .HD(8), .HF(2), .HR(3), .HB(3),
        .VD(4), .VF(1), .VR(1), .VB(2),
        .PIX_DLY(1), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .RGB(RGB),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked),
        .line_len(line_len), .frame_lines(frame_lines), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One frame from the source. Pixels at (gy,gx) before (lim_y,lim_x) are expected
    // at the output when exp_en is set; rst pulses at gx=10 of line rst_y.
    task automatic gen_frame(input int n_lines, input int stretch_y, input bit exp_en,
                             input int lim_y, input int lim_x, input int rst_y);
        int len;
        logic [10:0] x, y;
        logic [11:0] c;
        for (int gy = 0; gy < n_lines; gy++) begin
            len = (gy == stretch_y) ? 17 : 16;
            for (int gx = 0; gx < len; gx++) begin
                @(negedge clk);
                if (gy == rst_y && gx == 11) begin
                    chk("rst_flags", 64'({pix_valid, locked, frame_start}), 64'd0);
                    chk("rst_err", 64'(err_cnt), 64'd0);
                    chk("rst_meas", 64'({line_len, frame_lines}), 64'd0);
                    chk("rst_pix", 64'({pix_x, pix_y, pix_rgb}), 64'd0);
                end
                rst    = (gy == rst_y && gx == 10);
                VGA_HS = (gx < 3);
                VGA_VS = (gy < 1);
                if (gy >= 3 && gy < 7 && gx >= 7 && gx < 15) begin
                    x   = 11'(gx - 7);
                    y   = 11'(gy - 3);
                    c   = 12'(x + 16 * y);
                    RGB = c;
                    if (exp_en && (gy < lim_y || (gy == lim_y && gx < lim_x))) begin
                        exp_q.push_back({x, y, c});
                    end
                end else begin
                    RGB = 12'hFFF;
                end
            end
        end
    endtask

    // Monitor: every valid pixel must match the next expected one; idle outputs read zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_start === 1'b1) fs_cnt++;
            if (pix_valid === 1'b1) begin
                chk("pix_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    chk("pix_xy_rgb", 64'({pix_x, pix_y, pix_rgb}), 64'(exp_q.pop_front()));
                    pix_seen++;
                end
            end else begin
                chk("pix_idle_zero", 64'({pix_valid, pix_x, pix_y, pix_rgb}), 64'd0);
            end
        end
    end

    initial begin
        int base;
        rst = 1'b1; VGA_HS = 1'b0; VGA_VS = 1'b0; RGB = 12'd0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("reset_locked", 64'(locked), 64'd0);
        chk("reset_meas", 64'({line_len, frame_lines, err_cnt}), 64'd0);
        rst = 1'b0;

        // Lock acquisition: locked only after the second full frame.
        gen_frame(8, -1, 1'b0, 8, 0, -1);
        gen_frame(8, -1, 1'b0, 8, 0, -1);
        chk("lock_after2_not_yet", 64'(locked), 64'd0);
        base = pix_seen;
        gen_frame(8, -1, 1'b1, 8, 0, -1);
        chk("lock_f3", 64'(locked), 64'd1);
        chk("line_len", 64'(line_len), 64'd16);
        chk("frame_lines", 64'(frame_lines), 64'd8);
        chk("err_cnt_f3", 64'(err_cnt), 64'd0);
        chk("frame_start_cnt", 64'(fs_cnt), 64'd3);
        chk("pix_per_frame", 64'(pix_seen - base), 64'd32);

        // Stretched line while locked: lose lock after rows y=0,1, then relock.
        gen_frame(8, -1, 1'b1, 8, 0, -1);
        base = pix_seen;
        gen_frame(8, 4, 1'b1, 5, 0, -1);
        chk("stretch_unlock", 64'(locked), 64'd0);
        chk("stretch_err", 64'(err_cnt), 64'd1);
        chk("stretch_pix", 64'(pix_seen - base), 64'd16);
        gen_frame(8, -1, 1'b0, 8, 0, -1);
        gen_frame(8, -1, 1'b0, 8, 0, -1);
        chk("relock_not_yet", 64'(locked), 64'd0);
        gen_frame(8, -1, 1'b1, 8, 0, -1);
        chk("relock", 64'(locked), 64'd1);

        // HS held low long enough to saturate the line counter.
        repeat (2048 + 8) begin
            @(negedge clk);
            VGA_HS = 1'b0; VGA_VS = 1'b0; RGB = 12'h5A5;
        end
        chk("sat_unlock", 64'(locked), 64'd0);
        chk("sat_err", 64'(err_cnt), 64'd2);
        repeat (3) begin @(negedge clk); VGA_HS = 1'b1; end
        repeat (4) begin @(negedge clk); VGA_HS = 1'b0; end
        chk("sat_no_wrap", 64'(line_len), 64'd2047);
        chk("sat_search", 64'(locked), 64'd0);

        // Relock, then reset in the middle of the active area.
        gen_frame(8, -1, 1'b0, 8, 0, -1);
        gen_frame(8, -1, 1'b0, 8, 0, -1);
        chk("pre_rst_err", 64'(err_cnt), 64'd2);
        gen_frame(8, -1, 1'b1, 4, 8, 4);
        chk("post_rst_unlock", 64'(locked), 64'd0);
        gen_frame(8, -1, 1'b0, 8, 0, -1);
        gen_frame(8, -1, 1'b0, 8, 0, -1);
        chk("rst_relock_not_yet", 64'(locked), 64'd0);
        gen_frame(8, -1, 1'b1, 8, 0, -1);
        chk("rst_relock", 64'(locked), 64'd1);

        // Alternating good (8-line) and bad (9-line) frames never lock.
        @(negedge clk); rst = 1'b1; VGA_HS = 1'b0; VGA_VS = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            gen_frame((i % 2 == 1) ? 9 : 8, -1, 1'b0, 8, 0, -1);
            chk("alt_no_lock", 64'(locked), 64'd0);
            chk("alt_err", 64'(err_cnt), 64'd0);
            if (i > 0) chk("alt_frame_lines", 64'(frame_lines), (i % 2 == 1) ? 64'd8 : 64'd9);
        end

        repeat (5) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
